// File: rtl/lii_pkg.sv
// Shared constants for the LII stream pack wrapper: tag and drop counter
// widths, plus the parameter legality check used at elaboration.
package lii_pkg;

  localparam int TAG_W     = 8;
  localparam int DROP_W    = 16;
  localparam int MIN_DEPTH = 2;

  // Legal when all output slots fit the phy word, the kernel input fits the
  // phy word, and the FIFO depth is a power of two of at least MIN_DEPTH.
  function automatic bit lii_params_ok(input int nout, input int ow, input int iw,
                                       input int pw, input int depth);
    return (nout * ow <= pw) && (iw <= pw) && (depth >= MIN_DEPTH) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/lii_stream_if.sv
// Valid/ready stream bundle. The master drives data and valid; the slave
// drives ready.
interface lii_stream_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/lii_sync_fifo.sv
// Single-clock FIFO of DEPTH entries (power of two). The write side takes
// beats on wr.tvalid & wr.tready; the read side exposes the head entry and
// pops on rd.tvalid & rd.tready. Pointers wrap naturally modulo DEPTH.
module lii_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  lii_stream_if.slave   wr,
  lii_stream_if.master  rd,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;
  logic          pop;

  assign wr.tready = (cnt_q != CW'(DEPTH));
  assign rd.tvalid = (cnt_q != '0);
  assign rd.tdata  = mem_q[rd_ptr_q];
  assign count     = cnt_q;
  assign push      = wr.tvalid & wr.tready;
  assign pop       = rd.tvalid & rd.tready;

  // Advance pointers and occupancy; a simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr.tdata;
  end

endmodule

// File: rtl/lii_stream_pack_wrapper.sv
// LII stream pack wrapper. The phy input is filtered by destination id and
// fed to the kernel through a 2-entry skid buffer; NOUT kernel output streams
// are buffered in per-stream FIFOs and packed into one phy output beat.
// Optional feature macro: LII_PACK_CE_GATE_EN gates the kernel clock enable
// on FIFO headroom and kernel input stalls; otherwise ce is tied high.
module lii_stream_pack_wrapper
  import lii_pkg::*;
#(
  parameter int NOUT   = 2,
  parameter int OW     = 32,
  parameter int IW     = 17,
  parameter int PW     = 64,
  parameter int DEPTH  = 4,
  parameter int MY_ID  = 0,
  parameter int DST_ID = 0
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic [PW-1:0]        lii_in_p0_tdata,
  input  logic                 lii_in_p0_tvalid,
  output logic                 lii_in_p0_tready,
  input  logic [TAG_W-1:0]     lii_in_p0_src,
  input  logic [TAG_W-1:0]     lii_in_p0_dst,
  output logic [PW-1:0]        lii_out_p0_tdata,
  output logic                 lii_out_p0_tvalid,
  input  logic                 lii_out_p0_tready,
  output logic [TAG_W-1:0]     lii_out_p0_src,
  output logic [TAG_W-1:0]     lii_out_p0_dst,
  output logic [IW-1:0]        kin_tdata,
  output logic                 kin_tvalid,
  input  logic                 kin_tready,
  input  logic [NOUT*OW-1:0]   kout_tdata,
  input  logic [NOUT-1:0]      kout_tvalid,
  output logic [NOUT-1:0]      kout_tready,
  output logic                 ce,
  output logic [DROP_W-1:0]    drop_cnt
);

  localparam bit PARAMS_OK = lii_params_ok(NOUT, OW, IW, PW, DEPTH);
  localparam int CW        = $clog2(DEPTH) + 1;

  if (!PARAMS_OK) begin : g_bad_params
    $error("lii_stream_pack_wrapper: illegal parameter combination");
  end

  logic [IW-1:0]           skid0_q, skid0_d;
  logic [IW-1:0]           skid1_q, skid1_d;
  logic [1:0]              skid_cnt_q, skid_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic [DROP_W-1:0]       drop_q, drop_d;
  logic                    in_accept;
  logic                    in_match;
  logic                    kin_pop;
  logic                    out_valid_q, out_valid_d;
  logic [PW-1:0]           out_data_q, out_data_d;
  logic                    pack;
  logic [NOUT-1:0]         fifo_nonempty;
  logic [NOUT*OW-1:0]      fifo_head;
  logic [NOUT-1:0][CW-1:0] fifo_cnt;
  logic                    unused_inputs;

  // The source tag and the phy bits above the kernel width carry nothing here.
  assign unused_inputs = ^{lii_in_p0_src, lii_in_p0_tdata};

  assign in_accept = lii_in_p0_tvalid & in_ready_q;
  assign in_match  = (lii_in_p0_dst == TAG_W'(MY_ID));
  assign kin_pop   = kin_tvalid & kin_tready;

  assign lii_in_p0_tready = in_ready_q;
  assign kin_tvalid       = (skid_cnt_q != 2'd0);
  assign kin_tdata        = skid0_q;
  assign drop_cnt         = drop_q;

  // Skid buffer: pop the head to the kernel, append matching beats behind it,
  // count mismatching beats as drops, and precompute next-cycle ready.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    drop_d     = drop_q;
    if (kin_pop) begin
      skid0_d    = skid1_q;
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
    if (in_accept && in_match) begin
      if (skid_cnt_d == 2'd0) skid0_d = lii_in_p0_tdata[IW-1:0];
      else                    skid1_d = lii_in_p0_tdata[IW-1:0];
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
    if (in_accept && !in_match && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
    in_ready_d = (skid_cnt_d < 2'd2);
  end

  // Input-side registers; ready stays low through reset and rises one edge after.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= '0;
      in_ready_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      skid_cnt_q <= skid_cnt_d;
      in_ready_q <= in_ready_d;
      drop_q     <= drop_d;
    end
  end

  for (genvar i = 0; i < NOUT; i++) begin : g_fifo
    lii_stream_if #(.W(OW)) wr_if ();
    lii_stream_if #(.W(OW)) rd_if ();

    assign wr_if.tdata    = kout_tdata[i*OW +: OW];
    assign wr_if.tvalid   = kout_tvalid[i];
    assign kout_tready[i] = wr_if.tready;
    assign rd_if.tready   = pack;
    assign fifo_nonempty[i] = rd_if.tvalid;
    assign fifo_head[(NOUT-1-i)*OW +: OW] = rd_if.tdata;

    lii_sync_fifo #(
      .W     (OW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (aclk),
      .rst_n (arstn),
      .wr    (wr_if),
      .rd    (rd_if),
      .count (fifo_cnt[i])
    );
  end

  assign pack = (&fifo_nonempty) & (~out_valid_q | lii_out_p0_tready);

  // Output register: load a fresh pack when empty or draining, else clear on drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pack) begin
      out_valid_d = 1'b1;
      out_data_d  = PW'(fifo_head);
    end else if (lii_out_p0_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output beat register; reset clears both valid and data.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign lii_out_p0_tvalid = out_valid_q;
  assign lii_out_p0_tdata  = out_data_q;
  assign lii_out_p0_src    = TAG_W'(MY_ID);
  assign lii_out_p0_dst    = TAG_W'(DST_ID);

`ifdef LII_PACK_CE_GATE_EN
  logic ce_ok;

  // Hold the kernel when any FIFO is within one slot of full or kin is stalled.
  always_comb begin
    ce_ok = ~(kin_tvalid & ~kin_tready);
    for (int i = 0; i < NOUT; i++) begin
      if (fifo_cnt[i] > CW'(DEPTH - 2)) ce_ok = 1'b0;
    end
  end

  assign ce = ce_ok;
`else
  logic unused_fifo_cnt;
  assign unused_fifo_cnt = ^fifo_cnt;
  assign ce = 1'b1;
`endif

endmodule

// File: tb/tb_lii_stream_pack_wrapper.sv
// Self-checking bench for lii_stream_pack_wrapper: directed scenarios plus a
// randomized phase, checked every cycle against a queue-based reference model.
module tb_lii_stream_pack_wrapper;

  localparam int NOUT   = 2;
  localparam int OW     = 32;
  localparam int IW     = 17;
  localparam int PW     = 64;
  localparam int DEPTH  = 4;
  localparam int MY_ID  = 0;
  localparam int DST_ID = 0;

  logic aclk  = 1'b0;
  logic arstn = 1'b0;

  lii_stream_if #(.W(PW)) in_if ();
  lii_stream_if #(.W(PW)) out_if ();
  lii_stream_if #(.W(IW)) kin_if ();

  logic [7:0]         in_src, in_dst, out_src, out_dst;
  logic [NOUT*OW-1:0] kout_tdata;
  logic [NOUT-1:0]    kout_tvalid, kout_tready;
  logic               ce;
  logic [15:0]        drop_cnt;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int dut_out_beats = 0;
  int beat_cycles[$];

  // Reference model state
  logic [IW-1:0] m_kin_q[$];
  logic [OW-1:0] m_fifo_q[NOUT][$];
  bit            m_in_rdy;
  int            m_drop;
  bit            m_out_valid;
  logic [PW-1:0] m_out_data;

  always #5 aclk = ~aclk;

  lii_stream_pack_wrapper #(
    .NOUT(NOUT), .OW(OW), .IW(IW), .PW(PW), .DEPTH(DEPTH), .MY_ID(MY_ID), .DST_ID(DST_ID)
  ) dut (
    .aclk              (aclk),
    .arstn             (arstn),
    .lii_in_p0_tdata   (in_if.tdata),
    .lii_in_p0_tvalid  (in_if.tvalid),
    .lii_in_p0_tready  (in_if.tready),
    .lii_in_p0_src     (in_src),
    .lii_in_p0_dst     (in_dst),
    .lii_out_p0_tdata  (out_if.tdata),
    .lii_out_p0_tvalid (out_if.tvalid),
    .lii_out_p0_tready (out_if.tready),
    .lii_out_p0_src    (out_src),
    .lii_out_p0_dst    (out_dst),
    .kin_tdata         (kin_if.tdata),
    .kin_tvalid        (kin_if.tvalid),
    .kin_tready        (kin_if.tready),
    .kout_tdata        (kout_tdata),
    .kout_tvalid       (kout_tvalid),
    .kout_tready       (kout_tready),
    .ce                (ce),
    .drop_cnt          (drop_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cycle);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [PW-1:0] data, input logic [7:0] dst);
    int guard = 0;
    in_if.tdata  = data;
    in_dst       = dst;
    in_src       = 8'h5A;
    in_if.tvalid = 1'b1;
    while (!in_if.tready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) checkOutput("in_ready_timeout", 64'(in_if.tready), 64'd1);
    tick();
    in_if.tvalid = 1'b0;
  endtask

  task automatic pushStream(input int i, input logic [OW-1:0] data);
    int guard = 0;
    kout_tdata[i*OW +: OW] = data;
    kout_tvalid[i] = 1'b1;
    while (!kout_tready[i] && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) checkOutput("kout_ready_timeout", 64'(kout_tready[i]), 64'd1);
    tick();
    kout_tvalid[i] = 1'b0;
  endtask

  always @(posedge aclk) cycle++;

  // Reference model: queues for the skid buffer and FIFOs, one output slot.
  always @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      m_kin_q.delete();
      for (int i = 0; i < NOUT; i++) m_fifo_q[i].delete();
      m_in_rdy    = 1'b0;
      m_drop      = 0;
      m_out_valid = 1'b0;
      m_out_data  = '0;
    end else begin
      bit rdy [NOUT];
      bit all_ne;
      bit do_pack;
      all_ne = 1'b1;
      for (int i = 0; i < NOUT; i++) begin
        rdy[i] = (m_fifo_q[i].size() < DEPTH);
        if (m_fifo_q[i].size() == 0) all_ne = 1'b0;
      end
      do_pack = all_ne && (!m_out_valid || out_if.tready);
      if (do_pack) begin
        m_out_data = '0;
        for (int i = 0; i < NOUT; i++) m_out_data[(NOUT-1-i)*OW +: OW] = m_fifo_q[i].pop_front();
        m_out_valid = 1'b1;
      end else if (out_if.tready) begin
        m_out_valid = 1'b0;
      end
      for (int i = 0; i < NOUT; i++) begin
        if (kout_tvalid[i] && rdy[i]) m_fifo_q[i].push_back(kout_tdata[i*OW +: OW]);
      end
      if (m_kin_q.size() > 0 && kin_if.tready) void'(m_kin_q.pop_front());
      if (m_in_rdy && in_if.tvalid) begin
        if (in_dst == 8'(MY_ID)) m_kin_q.push_back(in_if.tdata[IW-1:0]);
        else if (m_drop < 65535) m_drop++;
      end
      m_in_rdy = (m_kin_q.size() < 2);
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge aclk) begin
    logic [NOUT-1:0] exp_krdy;
    bit              exp_ce;
    for (int i = 0; i < NOUT; i++) exp_krdy[i] = (m_fifo_q[i].size() < DEPTH);
`ifdef LII_PACK_CE_GATE_EN
    exp_ce = !(m_kin_q.size() > 0 && !kin_if.tready);
    for (int i = 0; i < NOUT; i++) if (m_fifo_q[i].size() > DEPTH - 2) exp_ce = 1'b0;
`else
    exp_ce = 1'b1;
`endif
    checkOutput("in_tready", 64'(in_if.tready), 64'(m_in_rdy));
    checkOutput("kin_tvalid", 64'(kin_if.tvalid), 64'(m_kin_q.size() > 0));
    if (m_kin_q.size() > 0) checkOutput("kin_tdata", 64'(kin_if.tdata), 64'(m_kin_q[0]));
    checkOutput("kout_tready", 64'(kout_tready), 64'(exp_krdy));
    checkOutput("out_tvalid", 64'(out_if.tvalid), 64'(m_out_valid));
    if (m_out_valid || !arstn) checkOutput("out_tdata", out_if.tdata, m_out_data);
    checkOutput("out_src", 64'(out_src), 64'(MY_ID));
    checkOutput("out_dst", 64'(out_dst), 64'(DST_ID));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    checkOutput("ce", 64'(ce), 64'(exp_ce));
    if (out_if.tvalid && out_if.tready) begin
      dut_out_beats++;
      beat_cycles.push_back(cycle);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int full_at;
    int base;
    int n;
    int guard;
    int span;

    in_if.tdata   = '0;
    in_if.tvalid  = 1'b0;
    in_src        = '0;
    in_dst        = '0;
    out_if.tready = 1'b0;
    kin_if.tready = 1'b0;
    kout_tdata    = '0;
    kout_tvalid   = '0;

    // Reset state
    repeat (3) tick();
    checkOutput("reset_in_ready", 64'(in_if.tready), 64'd0);
    checkOutput("reset_kin_valid", 64'(kin_if.tvalid), 64'd0);
    checkOutput("reset_out_valid", 64'(out_if.tvalid), 64'd0);
    checkOutput("reset_out_data", out_if.tdata, 64'd0);
    @(posedge aclk);
    #2 arstn = 1'b1;
    #1 checkOutput("release_in_ready_before_edge", 64'(in_if.tready), 64'd0);
    tick();
    checkOutput("release_in_ready_after_edge", 64'(in_if.tready), 64'd1);

    // Matching input beat reaches kin one cycle later
    applyStimulus(64'h1ABCD, 8'(MY_ID));
    checkOutput("kin_beat_valid", 64'(kin_if.tvalid), 64'd1);
    checkOutput("kin_beat_data", 64'(kin_if.tdata), 64'h1ABCD);
    checkOutput("kin_beat_drop", 64'(drop_cnt), 64'd0);
    kin_if.tready = 1'b1;
    tick();
    checkOutput("kin_drained", 64'(kin_if.tvalid), 64'd0);

    // Mismatching destination is dropped
    applyStimulus(64'h5555, 8'(MY_ID + 1));
    checkOutput("drop_no_kin", 64'(kin_if.tvalid), 64'd0);
    checkOutput("drop_count_one", 64'(drop_cnt), 64'd1);

    // Pack latency: stream 0 at cycle 0, stream 1 at cycle 3, valid at cycle 5
    kout_tdata[0 +: OW] = 32'h11111111;
    kout_tvalid = 2'b01;
    tick();
    kout_tvalid = 2'b00;
    tick();
    tick();
    kout_tdata[OW +: OW] = 32'h22222222;
    kout_tvalid = 2'b10;
    tick();
    kout_tvalid = 2'b00;
    checkOutput("pack_cycle4_invalid", 64'(out_if.tvalid), 64'd0);
    tick();
    checkOutput("pack_cycle5_valid", 64'(out_if.tvalid), 64'd1);
    checkOutput("pack_cycle5_data", out_if.tdata, 64'h1111111122222222);
    out_if.tready = 1'b1;
    tick();
    checkOutput("pack_drained", 64'(out_if.tvalid), 64'd0);

    // Backpressure: output stalled for 10 cycles while stream 0 keeps pushing
    out_if.tready = 1'b0;
    pushStream(1, 32'h0B000001);
    k = 0;
    full_at = -1;
    kout_tvalid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      kout_tdata[0 +: OW] = 32'hA0000000 + 32'(k);
`ifdef LII_PACK_CE_GATE_EN
      if (k == DEPTH - 1) checkOutput("ce_below_threshold", 64'(ce), 64'd1);
      if (k == DEPTH) checkOutput("ce_at_depth_minus_1", 64'(ce), 64'd0);
`else
      if (k == DEPTH) checkOutput("ce_tied_high", 64'(ce), 64'd1);
`endif
      if (kout_tready[0]) k++;
      else if (full_at < 0) full_at = k;
      tick();
    end
    kout_tvalid[0] = 1'b0;
    checkOutput("kout_ready_fall_after", 64'(full_at), 64'(DEPTH + 1));
    base = dut_out_beats;
    out_if.tready = 1'b1;
    for (int j = 0; j < DEPTH; j++) pushStream(1, 32'h0B000002 + 32'(j));
    repeat (10) tick();
    checkOutput("backpressure_beats", 64'(dut_out_beats - base), 64'(DEPTH + 1));

    // Streaming 100 beats with all readies high
    beat_cycles.delete();
    kout_tvalid = '1;
    n = 0;
    guard = 0;
    while (n < 100 && guard < 300) begin
      kout_tdata = {32'hD0000000 + 32'(n), 32'hC0000000 + 32'(n)};
      if (&kout_tready) n++;
      guard++;
      tick();
    end
    kout_tvalid = '0;
    repeat (8) tick();
    span = (beat_cycles.size() > 0) ? beat_cycles[$] - beat_cycles[0] : -1;
    checkOutput("stream_beat_count", 64'(beat_cycles.size()), 64'd100);
    checkOutput("stream_back_to_back", 64'(span), 64'd99);

    // Reset mid-transfer discards buffered data
    out_if.tready = 1'b0;
    kin_if.tready = 1'b0;
    pushStream(0, 32'hE0000000);
    pushStream(0, 32'hE0000001);
    pushStream(0, 32'hE0000002);
    pushStream(1, 32'hF0000000);
    applyStimulus(64'h00AA, 8'(MY_ID));
    applyStimulus(64'h00BB, 8'(MY_ID));
    tick();
    @(posedge aclk);
    #2 arstn = 1'b0;
    #1;
    checkOutput("midreset_kin_valid", 64'(kin_if.tvalid), 64'd0);
    checkOutput("midreset_out_valid", 64'(out_if.tvalid), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_if.tready), 64'd0);
    repeat (2) @(posedge aclk);
    #2 arstn = 1'b1;
    #1 checkOutput("rerelease_in_ready_before_edge", 64'(in_if.tready), 64'd0);
    tick();
    checkOutput("rerelease_in_ready_after_edge", 64'(in_if.tready), 64'd1);
    base = dut_out_beats;
    out_if.tready = 1'b1;
    kin_if.tready = 1'b1;
    repeat (6) tick();
    checkOutput("no_stale_out_beat", 64'(dut_out_beats - base), 64'd0);
    pushStream(0, 32'hE0000005);
    pushStream(1, 32'hF0000005);
    tick();
    checkOutput("post_reset_pack_valid", 64'(out_if.tvalid), 64'd1);
    checkOutput("post_reset_pack_data", out_if.tdata, 64'hE0000005F0000005);

    // Randomized traffic on all interfaces
    for (int c = 0; c < 3000; c++) begin
      in_if.tvalid  = 1'($urandom_range(0, 1));
      in_if.tdata   = {$urandom, $urandom};
      in_dst        = ($urandom_range(0, 3) == 0) ? 8'(MY_ID + 1) : 8'(MY_ID);
      in_src        = 8'($urandom);
      kin_if.tready = 1'($urandom_range(0, 1));
      out_if.tready = ($urandom_range(0, 3) != 0);
      kout_tvalid   = NOUT'($urandom);
      kout_tdata    = {$urandom, $urandom};
      tick();
    end
    in_if.tvalid  = 1'b0;
    kout_tvalid   = '0;
    kin_if.tready = 1'b1;
    out_if.tready = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lii_stream_pack_wrapper.md
LII_STREAM_PACK_WRAPPER -- requirements
Module: lii_stream_pack_wrapper

Interface
REQ-001 Parameters SHALL be as follows; legal only if NOUT*OW <= PW and IW <= PW:
- NOUT, default 2: number of kernel output streams.
- OW, default 32: width of each output stream.
- IW, default 17: width of the kernel input stream.
- PW, default 64: phy packing width.
- DEPTH, default 4: per-output FIFO depth, power of 2, at least 2.
- MY_ID, default 0: local node id.
- DST_ID, default 0: destination id stamped on output beats.
REQ-002 Ports SHALL be as follows:
- aclk  in  1  sole clock.
- arstn  in  1  reset, asynchronous, active-low.
- lii_in_p0_tdata/tvalid/tready  in/in/out  PW/1/1  phy input stream.
- lii_in_p0_src, lii_in_p0_dst  in  8 each  input beat tags.
- lii_out_p0_tdata/tvalid/tready  out/out/in  PW/1/1  phy output stream.
- lii_out_p0_src, lii_out_p0_dst  out  8 each  output beat tags.
- kin_tdata/tvalid/tready  out/out/in  IW/1/1  stream to the kernel.
- kout_tdata/tvalid/tready  in/in/out  NOUT*OW/NOUT/NOUT  flattened kernel output streams; stream i occupies bits [i*OW +: OW].
- ce  out  1  kernel clock enable.
- drop_cnt  out  16  count of dropped input beats.

Function
REQ-003 The input path SHALL be a 2-entry skid buffer; lii_in_p0_tready SHALL be registered and high iff the buffer holds fewer than 2 entries.
REQ-004 An accepted input beat with lii_in_p0_dst == MY_ID SHALL appear on kin_tdata as tdata[IW-1:0], with kin_tvalid high on the next cycle (latency 1).
REQ-005 An accepted beat with dst != MY_ID SHALL be discarded without reaching kin.
REQ-006 Each discarded beat SHALL increment drop_cnt; drop_cnt SHALL saturate at 0xFFFF.
REQ-007 kin_tvalid/kin_tdata SHALL stay stable until kin_tready is high; beats SHALL reach kin in arrival order.
REQ-008 Each kernel output stream i SHALL own a FIFO of DEPTH entries; kout_tready[i] SHALL be high iff FIFO i is not full.
REQ-009 Each kernel output stream i SHALL be written independently on kout_tvalid[i] & kout_tready[i].
REQ-010 A pack SHALL occur when every FIFO is non-empty and the output register is empty or draining this cycle; a pack pops exactly one entry from every FIFO in the same cycle.
REQ-011 The output register SHALL load stream 0 into the most-significant slot [NOUT*OW-1 -: OW], stream NOUT-1 into the least-significant slot, and zero bits [PW-1:NOUT*OW].
REQ-012 lii_out_p0_src SHALL equal MY_ID and lii_out_p0_dst SHALL equal DST_ID.
REQ-013 lii_out_p0_tvalid SHALL be registered, rise 2 cycles after the last of the NOUT streams' beats is written into the FIFOs, and hold with stable data until lii_out_p0_tready.
REQ-014 With the output register full and lii_out_p0_tready high, a new pack SHALL load in the same cycle, sustaining 1 beat per cycle.
REQ-015 Simultaneous FIFO push and pop SHALL leave the FIFO count unchanged; a push into a full FIFO SHALL NOT occur.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH.
REQ-017 Unequal producer rates SHALL cause no reordering, loss or duplication within any stream.

Reset
REQ-018 While arstn is low, the following SHALL be 0: skid buffer and FIFOs (empty), lii_in_p0_tready, kin_tvalid, lii_out_p0_tvalid, lii_out_p0_tdata, drop_cnt.
REQ-019 An assertion of arstn mid-transfer SHALL discard all buffered data; no partial or stale beat SHALL be emitted after release.
REQ-020 lii_in_p0_tready SHALL rise on the first aclk edge after arstn releases.

Configuration
REQ-021 With macro LII_PACK_CE_GATE_EN defined, ce SHALL be high iff every output FIFO holds at most DEPTH-2 entries and kin is not stalled (no kin_tvalid & ~kin_tready).
REQ-022 With LII_PACK_CE_GATE_EN undefined, ce SHALL be tied to 1.

Structure
REQ-023 Package lii_pkg SHALL hold the tag width (8), the drop counter width (16) and the parameter legality check constants.
REQ-024 The per-stream FIFO SHALL be a sub-module lii_sync_fifo, instantiated NOUT times.

Verification
REQ-025 Bench SHALL cover:
- Reset then one input beat 0x1_ABCD with dst=MY_ID -> kin_tdata=0x1ABCD one cycle later; drop_cnt=0.
- Input beat with dst=MY_ID+1 -> no kin beat; drop_cnt=1.
- kout[0]=0x11111111 at cycle 0 and kout[1]=0x22222222 at cycle 3 -> lii_out_p0_tdata=0x1111111122222222 with tvalid at cycle 5.
- lii_out_p0_tready held low for 10 cycles while stream 0 keeps pushing -> kout_tready[0] falls after DEPTH+1 beats; ce falls when FIFO 0 reaches DEPTH-1 (macro on); all beats later emerge in order.
- Streaming 100 beats, all readies high -> 100 output beats on consecutive cycles after the initial latency.
- arstn pulsed low with 3 beats buffered -> all valids 0; no beat emitted after release; lii_in_p0_tready high one edge after release.
